// File: rtl/spi_wb_pkg.sv
// Shared definitions for the Wishbone SPI master: register word addresses,
// CTRL/STATUS bit positions and the transfer FSM state encoding.
package spi_wb_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_RXDATA = 2'd3;

  localparam int CTRL_CS      = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_DIV_LSB = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  // One byte = 8 bits = 16 SCK edges.
  localparam logic [4:0] XFER_EDGES = 5'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Single-byte SPI shift engine: clock divider, SCK edge counter, TX/RX
// shifters and SCK/MOSI generation for all four CPOL/CPHA modes.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   start_i             one-cycle request to begin a transfer (ignored when busy)
//   cpol_i, cpha_i      live mode bits; CPOL also sets the idle SCK level
//   clk_div_i           SCK half-period = clk_div_i+1 clk cycles
//   tx_i                byte to send, captured on start
//   miso_i              serial input
//   busy_o              transfer in progress
//   done_o              combinational strobe: the transfer ends on this edge
//   rx_o                last received byte
//   sck_o, mosi_o       registered SPI outputs
module spi_shift_engine
  import spi_wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic [7:0] clk_div_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_o,
  output logic       sck_o,
  output logic       mosi_o
);

  spi_state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] lim_q, lim_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rxout_q, rxout_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       fin_s;
  logic       leading_s;
  logic       sample_s;
  logic [7:0] rx_shift_s;

  // Next-state logic for the transfer FSM and its datapath
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxout_d = rxout_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    fin_s   = 1'b0;
    // The counter starts at 16, so an even count means an odd (leading) edge.
    leading_s  = ~cnt_q[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    sample_s   = cpha_q ^ leading_s;
    rx_shift_s = {rx_q[6:0], miso_i};
    case (state_q)
      ST_IDLE: begin
        sck_d = cpol_i;
        if (start_i) begin
          state_d = ST_XFER;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          lim_d   = clk_div_i;
          cnt_d   = XFER_EDGES;
          div_d   = 8'd0;
          tx_d    = tx_i;
          rx_d    = 8'd0;
          // CPHA=0 must present the MSB before the first (sampling) edge.
          if (cpha_i) begin
            mosi_d = mosi_q;
          end else begin
            mosi_d = tx_i[7];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (div_q == lim_q) begin
          div_d = 8'd0;
          sck_d = ~sck_q;
          cnt_d = cnt_q - 5'd1;
          if (sample_s) begin
            rx_d = rx_shift_s;
          end else if (cpha_q) begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else if (cnt_q != 5'd1) begin
            // CPHA=0 already showed bit 7 at start; the last trailing edge
            // has no bit left, so MOSI keeps bit 0.
            mosi_d = tx_q[6];
            tx_d   = {tx_q[6:0], 1'b0};
          end else begin
            mosi_d = mosi_q;
          end
          if (cnt_q == 5'd1) begin
            state_d = ST_IDLE;
            fin_s   = 1'b1;
            sck_d   = cpol_q;
            rxout_d = sample_s ? rx_shift_s : rx_q;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      div_q   <= 8'd0;
      lim_q   <= 8'd0;
      cnt_q   <= 5'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      rxout_q <= 8'd0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxout_q <= rxout_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
    end
  end

  assign busy_o = (state_q == ST_XFER);
  assign done_o = fin_s;
  assign rx_o   = rxout_q;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone-pipelined slave exposing a 4-word register map (CTRL, STATUS,
// TXDATA, RXDATA) that drives a single-byte SPI master.
// Ports:
//   clk_i, rst_i          clock, async active-low reset (release synchronised)
//   wb_*                  Wishbone slave; one registered ack per cyc&stb
//   spi_sck_o/mosi_o/cs_n_o, spi_miso_i   SPI pins
//   irq_o                 registered done & irq_en
module wb_spi_master
  import spi_wb_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]   wb_data_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_stall_o,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_data_o,
  output logic            spi_sck_o,
  output logic            spi_mosi_o,
  input  logic            spi_miso_i,
  output logic            spi_cs_n_o,
  output logic            irq_o
);

  logic [1:0]    rst_sync_q;
  logic          rst_n_s;
  logic [3:0]    ctrl_lo_q, ctrl_lo_d;
  logic [7:0]    clk_div_q, clk_div_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    tx_last_q, tx_last_d;
  logic          ack_q;
  logic [DW-1:0] rdata_q, rdata_s;
  logic          irq_q;
  logic          req_s, wr_s, rd_s;
  logic [1:0]    addr_s;
  logic          start_s, busy_s, eng_done_s;
  logic [7:0]    rx_s;
  logic          unused_s;

  assign req_s  = wb_cyc_i & wb_stb_i;
  assign wr_s   = req_s & wb_we_i;
  assign rd_s   = req_s & ~wb_we_i;
  assign addr_s = wb_addr_i[1:0];
  assign unused_s = ^{wb_addr_i, wb_data_i, wb_sel_i};

  // Reset assertion is immediate; release is synchronised to clk_i
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  // Read mux and register-file next state
  always_comb begin
    ctrl_lo_d = ctrl_lo_q;
    clk_div_d = clk_div_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    tx_last_d = tx_last_q;
    start_s   = 1'b0;
    rdata_s   = {DW{1'b0}};
    case (addr_s)
      ADDR_CTRL: begin
        rdata_s[3:0]  = ctrl_lo_q;
        rdata_s[15:8] = clk_div_q;
      end
      ADDR_STATUS: begin
        rdata_s[STAT_BUSY] = busy_s;
        rdata_s[STAT_DONE] = done_q;
        rdata_s[STAT_OVR]  = ovr_q;
      end
      ADDR_TXDATA: rdata_s[7:0] = tx_last_q;
      ADDR_RXDATA: rdata_s[7:0] = rx_s;
      default:     rdata_s = {DW{1'b0}};
    endcase

    if (wr_s && addr_s == ADDR_CTRL) begin
      if (wb_sel_i[0]) begin
        ctrl_lo_d = wb_data_i[3:0];
      end else begin
        ctrl_lo_d = ctrl_lo_q;
      end
      if (wb_sel_i[1]) begin
        clk_div_d = wb_data_i[CTRL_DIV_LSB +: 8];
      end else begin
        clk_div_d = clk_div_q;
      end
    end else begin
      ctrl_lo_d = ctrl_lo_q;
    end

    // busy_s is still high in the cycle the engine finishes, so a write
    // landing there counts as an overrun.
    if (wr_s && addr_s == ADDR_TXDATA && wb_sel_i[0]) begin
      if (busy_s) begin
        ovr_d = 1'b1;
      end else begin
        start_s   = 1'b1;
        tx_last_d = wb_data_i[7:0];
      end
    end else if (wr_s && addr_s == ADDR_STATUS && wb_sel_i[0] && wb_data_i[STAT_OVR]) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    // Hardware set beats any clear in the same cycle.
    if (eng_done_s) begin
      done_d = 1'b1;
    end else if ((wr_s && addr_s == ADDR_STATUS && wb_sel_i[0] && wb_data_i[STAT_DONE]) ||
                 (rd_s && addr_s == ADDR_RXDATA)) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  // Register file, Wishbone response and interrupt registers
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ctrl_lo_q <= 4'd0;
      clk_div_q <= 8'd0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tx_last_q <= 8'd0;
      ack_q     <= 1'b0;
      rdata_q   <= {DW{1'b0}};
      irq_q     <= 1'b0;
    end else begin
      ctrl_lo_q <= ctrl_lo_d;
      clk_div_q <= clk_div_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      tx_last_q <= tx_last_d;
      ack_q     <= req_s;
      rdata_q   <= rd_s ? rdata_s : {DW{1'b0}};
      irq_q     <= done_q & ctrl_lo_q[CTRL_IRQ_EN];
    end
  end

  spi_shift_engine u_engine (
    .clk_i     (clk_i),
    .rst_ni    (rst_n_s),
    .start_i   (start_s),
    .cpol_i    (ctrl_lo_q[CTRL_CPOL]),
    .cpha_i    (ctrl_lo_q[CTRL_CPHA]),
    .clk_div_i (clk_div_q),
    .tx_i      (wb_data_i[7:0]),
    .miso_i    (spi_miso_i),
    .busy_o    (busy_s),
    .done_o    (eng_done_s),
    .rx_o      (rx_s),
    .sck_o     (spi_sck_o),
    .mosi_o    (spi_mosi_o)
  );

  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_data_o  = rdata_q;
  assign spi_cs_n_o = ~ctrl_lo_q[CTRL_CS];
  assign irq_o      = irq_q;

endmodule
